// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcode/funct
// encodings, ALU operation codes and the controller state encoding.
package mc_pkg;

    // Opcode field values recognised by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Funct field values decoded for R-type instructions
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU operation codes driven on alucontrol
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Internal aluop classes from the state machine to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Datapath select encodings
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Controller states, binary encoded with FETCH at zero so the reset
    // value and the all-zero register agree.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_e;

    // True when the opcode is one the controller can sequence.
    function automatic logic is_known_op(input logic [5:0] op);
        logic known_s;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: known_s = 1'b1;
            default:                                       known_s = 1'b0;
        endcase
        return known_s;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU decoder: maps the controller's aluop class and the
// instruction funct field onto the ALU operation code. Unknown funct values
// fall back to 3'b000 without any flag.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Select the ALU operation from aluop, decoding funct for R-type
    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control unit for the multi-cycle MIPS datapath. One state
// register sequences each instruction through fetch, decode and execute
// phases; memory-access states stretch on mem_ready_i. Write strobes are
// forced low while reset is held so no partial write escapes.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pcen_o,
    output logic       iord_o,
    output logic       memwrite_o,
    output logic       irwrite_o,
    output logic       memtoreg_o,
    output logic       regdst_o,
    output logic       regwrite_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] pcsrc_o,
    output logic [2:0] alucontrol_o,
    output logic       illegal_o
);

    state_e     state_r;
    state_e     state_next_s;

    logic       pcwrite_s;
    logic       branch_s;
    logic       iord_s;
    logic       memwrite_s;
    logic       irwrite_s;
    logic       memtoreg_s;
    logic       regdst_s;
    logic       regwrite_s;
    logic       alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] pcsrc_s;
    logic [1:0] aluop_s;
    logic       illegal_s;

    // State register: asynchronous return to FETCH on reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-state control decode; unlisted controls stay 0
    always_comb begin
        state_next_s = S_FETCH;
        pcwrite_s    = 1'b0;
        branch_s     = 1'b0;
        iord_s       = 1'b0;
        memwrite_s   = 1'b0;
        irwrite_s    = 1'b0;
        memtoreg_s   = 1'b0;
        regdst_s     = 1'b0;
        regwrite_s   = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = SRCB_REG;
        pcsrc_s      = PCSRC_ALU;
        aluop_s      = ALUOP_ADD;
        illegal_s    = 1'b0;

        case (state_r)
            S_FETCH: begin
                alusrcb_s = SRCB_FOUR;
                irwrite_s = mem_ready_i;
                pcwrite_s = mem_ready_i;
                if (mem_ready_i) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target while decoding
                alusrcb_s = SRCB_IMMSL2;
                case (op_i)
                    OP_LW, OP_SW: state_next_s = S_MEMADR;
                    OP_RTYPE:     state_next_s = S_RTYPEEX;
                    OP_BEQ:       state_next_s = S_BEQEX;
                    OP_ADDI:      state_next_s = S_ADDIEX;
                    OP_J:         state_next_s = S_JEX;
                    default:      state_next_s = S_FETCH;
                endcase
                illegal_s = ~is_known_op(op_i);
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = SRCB_IMM;
                if (op_i == OP_SW) begin
                    state_next_s = S_MEMWR;
                end else if (op_i == OP_LW) begin
                    state_next_s = S_MEMRD;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_MEMRD: begin
                iord_s = 1'b1;
                if (mem_ready_i) begin
                    state_next_s = S_MEMWB;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                memtoreg_s   = 1'b1;
                regwrite_s   = 1'b1;
                state_next_s = S_FETCH;
            end
            S_MEMWR: begin
                // Strobe held for every wait cycle until memory accepts
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                if (mem_ready_i) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEMWR;
                end
            end
            S_RTYPEEX: begin
                alusrca_s    = 1'b1;
                alusrcb_s    = SRCB_REG;
                aluop_s      = ALUOP_FUNCT;
                state_next_s = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst_s     = 1'b1;
                regwrite_s   = 1'b1;
                state_next_s = S_FETCH;
            end
            S_BEQEX: begin
                alusrca_s    = 1'b1;
                alusrcb_s    = SRCB_REG;
                aluop_s      = ALUOP_SUB;
                pcsrc_s      = PCSRC_ALUOUT;
                branch_s     = 1'b1;
                state_next_s = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_s    = 1'b1;
                alusrcb_s    = SRCB_IMM;
                state_next_s = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s   = 1'b1;
                state_next_s = S_FETCH;
            end
            S_JEX: begin
                pcsrc_s      = PCSRC_JUMP;
                pcwrite_s    = 1'b1;
                state_next_s = S_FETCH;
            end
            default: begin
                state_next_s = S_FETCH;
            end
        endcase
    end

    mc_alu_dec u_alu_dec (
        .aluop      (aluop_s),
        .funct      (funct_i),
        .alucontrol (alucontrol_o)
    );

    // Strobes are qualified by rst_n_i so they drop in the same cycle reset
    // asserts; selects already show FETCH values via the async state reset.
    assign pcen_o     = rst_n_i & (pcwrite_s | (branch_s & zero_i));
    assign irwrite_o  = rst_n_i & irwrite_s;
    assign memwrite_o = rst_n_i & memwrite_s;
    assign regwrite_o = rst_n_i & regwrite_s;

    assign iord_o     = iord_s;
    assign memtoreg_o = memtoreg_s;
    assign regdst_o   = regdst_s;
    assign alusrca_o  = alusrca_s;
    assign alusrcb_o  = alusrcb_s;
    assign pcsrc_o    = pcsrc_s;
    assign illegal_o  = illegal_s;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multi-cycle MIPS datapath. It sequences one instruction over 3–5 clock cycles through a Moore-style state machine that shares one memory port and one ALU across fetch, address and execute phases. A ready handshake stretches the memory-access states for memory wait cycles. It drives every datapath select and write strobe, and replaces the single-cycle decoder when the core is built in multi-cycle form.

## Interface
Parameters:
- none. Opcode, funct and ALU codes come from the shared package.

Ports:
- clk_i  input  1  core clock; all state changes occur on the rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- op_i  input  6  opcode field from the instruction register.
- funct_i  input  6  funct field from the instruction register.
- zero_i  input  1  ALU zero flag.
- mem_ready_i  input  1  memory has completed the current access this cycle.
- pcen_o  output  1  PC write enable, equal to pcwrite | (branch & zero_i).
- iord_o  output  1  memory address select: 0 selects PC, 1 selects ALUOut.
- memwrite_o  output  1  memory write strobe.
- irwrite_o  output  1  instruction register load.
- memtoreg_o  output  1  write-back source select: 1 selects the memory data register.
- regdst_o  output  1  write register select: 1 selects rd.
- regwrite_o  output  1  register file write strobe.
- alusrca_o  output  1  ALU input A select: 0 selects PC, 1 selects register A.
- alusrcb_o  output  2  ALU input B select: 00 B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2.
- pcsrc_o  output  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target.
- alucontrol_o  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal_o  output  1  one-cycle pulse in DECODE when the opcode is not recognised.

## Operation
- State register resets asynchronously to FETCH.
- While rst_n_i is low, every write strobe (pcen, irwrite, memwrite, regwrite) is 0 and every select output holds its FETCH value.
- Any signal not listed for a state is 0. aluop is an internal signal that feeds alucontrol_o.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=pcwrite=mem_ready_i. Goes to DECODE when mem_ready_i=1; otherwise stays in FETCH.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (computes the branch target). Next state by opcode:
  - lw (100011) and sw (101011) go to MEMADR.
  - R-type (000000) goes to RTYPEEX.
  - beq (000100) goes to BEQEX.
  - addi (001000) goes to ADDIEX.
  - j (000010) goes to JEX.
  - Any other opcode: illegal_o=1 and the next state is FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Goes to MEMWB when mem_ready_i=1; otherwise holds.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Goes to FETCH.
- MEMWR: iord=1, memwrite=1. Goes to FETCH when mem_ready_i=1. memwrite stays high for every wait cycle.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Goes to RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Goes to FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Goes to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Goes to FETCH.
- JEX: pcsrc=10, pcwrite=1. Goes to FETCH.
- ALU decode:
  - aluop 00 gives add.
  - aluop 01 gives sub.
  - aluop 10 decodes funct_i: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - An undefined funct gives 3'b000. This is not flagged.
- An R-type instruction with an unknown funct still completes the full sequence.

## Timing
- Outputs are combinational from the state. In FETCH, irwrite and pcwrite also depend on mem_ready_i; in BEQEX, pcen depends on zero_i.
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each low cycle of mem_ready_i during FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready_i is ignored in every other state.
- Reset asserted mid-instruction: the state goes to FETCH immediately and all strobes drop in the same cycle. No partial write completes after reset asserts.
- Reset deassertion: the first FETCH can complete on the first rising edge where rst_n_i is high and mem_ready_i=1.

## Structure
- Shared package mc_pkg holds:
  - Opcode and funct localparams.
  - ALU code localparams.
  - The state enum, 4-bit binary encoded, with FETCH = 0.
- Sub-module mc_alu_dec is the combinational aluop/funct to alucontrol decoder. It is kept separate for reuse and unit test.
- The top-level block holds the state register, next-state logic and output decode.

## Test plan
- Reset then lw with mem_ready_i tied to 1: states run FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite=1 and memtoreg=1 only in cycle 5. irwrite=1 only in cycle 1.
- sw with mem_ready_i low for 2 cycles during MEMWR: memwrite=1 for 3 consecutive cycles, then the state returns to FETCH. regwrite stays 0 throughout.
- beq run twice, once with zero_i=1 and once with zero_i=0: in BEQEX, pcen=1 with pcsrc=01 and alucontrol=110 for the first run; pcen=0 for the second. Each takes 3 cycles.
- R-type with funct 101010, followed by j: alucontrol=111 in RTYPEEX and regdst=1 in RTYPEWB. In JEX, pcsrc=10 and pcen=1.
- op_i=111111: illegal_o pulses for the single DECODE cycle, the next state is FETCH, and no regwrite or memwrite occurs.
- rst_n_i asserted low during MEMWR with a write pending: memwrite falls within the same cycle and the state reads FETCH. After release, a 3-cycle FETCH stall holds irwrite=0 until mem_ready_i goes high.
